// File: rtl/reg_bank_pkg.sv
// Shared definitions for the general-purpose register bank.
// Function-select encoding used by every register cell.
package reg_bank_pkg;

  // Operation applied by every enabled register on a rising edge.
  typedef enum logic [1:0] {
    FS_DEC  = 2'd0,
    FS_INC  = 2'd1,
    FS_LOAD = 2'd2,
    FS_CLR  = 2'd3
  } fun_sel_e;

  // Default geometry of the bank.
  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_NUM_REGS = 4;

endpackage

// File: rtl/reg_bank_cell.sv
// One register of the bank: a WIDTH-bit counter/loadable cell plus its
// sticky wrap flag. Exposes both the current value and the value it will
// take on the next edge, so the top level can forward it when needed.
// There is no handshake: whenever en_i is high the operation is applied on
// that edge, every edge.
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  fun_sel_e         fun_sel_i,
  input  logic             half_en_i,
  input  logic             half_sel_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             wrap_clr_i,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             wrap_q, wrap_d;
  logic             wrap_evt;

  // Next-state value and wrap event for the selected operation.
  always_comb begin
    reg_d    = reg_q;
    wrap_evt = 1'b0;
    if (en_i) begin
      case (fun_sel_i)
        FS_DEC: begin
          reg_d    = reg_q - ONE;
          wrap_evt = (reg_q == '0);
        end
        FS_INC: begin
          reg_d    = reg_q + ONE;
          wrap_evt = (&reg_q);
        end
        FS_LOAD: begin
          if (!half_en_i) begin
            reg_d = data_i;
          end else if (half_sel_i) begin
            reg_d[WIDTH-1:HALF] = data_i[HALF-1:0];
          end else begin
            reg_d[HALF-1:0] = data_i[HALF-1:0];
          end
        end
        FS_CLR: begin
          reg_d = '0;
        end
        default: begin
          reg_d = reg_q;
        end
      endcase
    end
  end

  // Sticky wrap flag: a wrap event on the same edge beats the bulk clear.
  always_comb begin
    wrap_d = wrap_q;
    if (wrap_clr_i) wrap_d = 1'b0;
    if (wrap_evt)   wrap_d = 1'b1;
  end

  // Register and flag state; reset forces both to zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      wrap_q <= wrap_d;
    end
  end

  assign value_o = reg_q;
  assign next_o  = reg_d;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank: NUM_REGS counter/loadable cells sharing one
// function select, two combinational read ports, zero and wrap vectors.
// Optional macro REG_BANK_BYPASS_EN: read ports and zero vector show the
// next-state value (write-through) instead of the current register state.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          fun_sel,
  input  logic [NUM_REGS-1:0] reg_sel,
  input  logic                half_en,
  input  logic                half_sel,
  input  logic [WIDTH-1:0]    i,
  input  logic                wrap_clr,
  input  logic [SEL_W-1:0]    out_a_sel,
  input  logic [SEL_W-1:0]    out_b_sel,
  output logic [WIDTH-1:0]    out_a,
  output logic [WIDTH-1:0]    out_b,
  output logic [NUM_REGS-1:0] zero,
  output logic [NUM_REGS-1:0] wrap
);

  fun_sel_e         fs;
  logic [WIDTH-1:0] cur_val [NUM_REGS];
  logic [WIDTH-1:0] nxt_val [NUM_REGS];
  logic [WIDTH-1:0] view    [NUM_REGS];

  assign fs = fun_sel_e'(fun_sel);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    reg_bank_cell #(.WIDTH(WIDTH)) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (~reg_sel[g]),
      .fun_sel_i  (fs),
      .half_en_i  (half_en),
      .half_sel_i (half_sel),
      .data_i     (i),
      .wrap_clr_i (wrap_clr),
      .value_o    (cur_val[g]),
      .next_o     (nxt_val[g]),
      .wrap_o     (wrap[g])
    );

`ifdef REG_BANK_BYPASS_EN
    // Next-state equals current state when the cell is disabled, so the
    // next-state value is the write-through view for every register.
    assign view[g] = nxt_val[g];
`else
    assign view[g] = cur_val[g];
`endif
  end

  // Read port A: out-of-range selects return zero.
  always_comb begin
    out_a = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (out_a_sel == SEL_W'(k)) out_a = view[k];
    end
  end

  // Read port B: out-of-range selects return zero.
  always_comb begin
    out_b = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (out_b_sel == SEL_W'(k)) out_b = view[k];
    end
  end

  // Per-register zero flags.
  always_comb begin
    zero = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      zero[k] = (view[k] == '0);
    end
  end

`ifndef REG_BANK_BYPASS_EN
  // Next-state values are only consumed in the write-through build.
  logic unused_nxt;
  always_comb begin
    unused_nxt = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      unused_nxt = unused_nxt ^ (^nxt_val[k]);
    end
  end
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Directed testbench for reg_bank (WIDTH=8, NUM_REGS=4).
module tb_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] fun_sel;
  logic [3:0] reg_sel;
  logic       half_en;
  logic       half_sel;
  logic [7:0] i;
  logic       wrap_clr;
  logic [1:0] out_a_sel;
  logic [1:0] out_b_sel;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [3:0] zero;
  logic [3:0] wrap;

  int checks   = 0;
  int failures = 0;

  reg_bank #(.WIDTH(8), .NUM_REGS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fun_sel   (fun_sel),
    .reg_sel   (reg_sel),
    .half_en   (half_en),
    .half_sel  (half_sel),
    .i         (i),
    .wrap_clr  (wrap_clr),
    .out_a_sel (out_a_sel),
    .out_b_sel (out_b_sel),
    .out_a     (out_a),
    .out_b     (out_b),
    .zero      (zero),
    .wrap      (wrap)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Select register on port A and settle.
  task automatic rd_a(input logic [1:0] idx);
    out_a_sel = idx;
    #1;
  endtask

  task automatic drive(input logic [1:0] fs, input logic [3:0] rs, input logic [7:0] d);
    fun_sel = fs;
    reg_sel = rs;
    i       = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    fun_sel   = 2'd0;
    reg_sel   = 4'hF;
    half_en   = 1'b0;
    half_sel  = 1'b0;
    i         = 8'h00;
    wrap_clr  = 1'b0;
    out_a_sel = 2'd0;
    out_b_sel = 2'd0;

    // Reset then read every select on both ports
    #12;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      out_a_sel = 2'(k);
      out_b_sel = 2'(3 - k);
      #1;
      chk("rst_out_a", out_a, 8'h00);
      chk("rst_out_b", out_b, 8'h00);
    end
    chk("rst_zero", zero, 4'b1111);
    chk("rst_wrap", wrap, 4'b0000);

    // Multi-select: all registers increment 3 times
    drive(2'd1, 4'b0000, 8'h00);
    step(); step(); step();
    for (int k = 0; k < 4; k++) begin
      rd_a(2'(k));
      chk("multi_inc", out_a, 8'h03);
    end
    chk("multi_zero", zero, 4'b0000);
    chk("multi_wrap", wrap, 4'b0000);
    reg_sel = 4'b1111;
    step();
    rd_a(2'd2);
    chk("hold_r2", out_a, 8'h03);

    // Clear all
    drive(2'd3, 4'b0000, 8'h00);
    step();
    chk("clr_zero", zero, 4'b1111);

    // Full then half loads into R2
    drive(2'd2, 4'b1011, 8'hA5);
    half_en = 1'b0;
    step();
    out_b_sel = 2'd1;
    rd_a(2'd2);
    chk("load_r2", out_a, 8'hA5);
    chk("load_r1_untouched", out_b, 8'h00);
    half_en  = 1'b1;
    half_sel = 1'b1;
    i        = 8'h3C;
    step();
    chk("half_hi_r2", out_a, 8'hC5);
    half_sel = 1'b0;
    i        = 8'h07;
    step();
    chk("half_lo_r2", out_a, 8'hC7);
    chk("half_zero", zero, 4'b1011);
    half_en = 1'b0;

    // Full load then decrement with borrow across nibble
    drive(2'd2, 4'b1011, 8'h10);
    step();
    fun_sel = 2'd0;
    step();
    chk("dec_borrow_r2", out_a, 8'h0F);
    chk("dec_borrow_wrap", wrap, 4'b0000);

    // Wrap on R0: clear, decrement, increment
    drive(2'd3, 4'b1110, 8'h00);
    step();
    fun_sel = 2'd0;
    step();
    rd_a(2'd0);
    chk("dec_wrap_r0", out_a, 8'hFF);
    chk("dec_wrap_flag", wrap, 4'b0001);
    fun_sel = 2'd1;
    step();
    chk("inc_wrap_r0", out_a, 8'h00);
    chk("inc_wrap_flag", wrap, 4'b0001);
    fun_sel = 2'd3;
    step();
    chk("clr_keeps_wrap", wrap, 4'b0001);
    reg_sel  = 4'b1111;
    wrap_clr = 1'b1;
    step();
    chk("wrap_clr", wrap, 4'b0000);
    wrap_clr = 1'b0;

    // Priority: R3 wraps (decrement from 0), then R1 wraps with wrap_clr
    drive(2'd0, 4'b0111, 8'h00);
    step();
    chk("r3_wrap", wrap, 4'b1000);
    drive(2'd2, 4'b1101, 8'hFF);
    step();
    fun_sel  = 2'd1;
    wrap_clr = 1'b1;
    step();
    wrap_clr = 1'b0;
    rd_a(2'd1);
    chk("prio_r1", out_a, 8'h00);
    chk("prio_wrap", wrap, 4'b0010);

    // Read-during-write on R1
    drive(2'd2, 4'b1101, 8'h5A);
    #1;
`ifdef REG_BANK_BYPASS_EN
    chk("rdw_before_edge", out_a, 8'h5A);
`else
    chk("rdw_before_edge", out_a, 8'h00);
`endif
    step();
    chk("rdw_after_edge", out_a, 8'h5A);

    // Reset mid-increment sequence
    fun_sel = 2'd1;
    step();
    step();
    chk("pre_reset_r1", out_a, 8'h5C);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_r1", out_a, 8'h00);
    chk("async_rst_zero", zero, 4'b1111);
    chk("async_rst_wrap", wrap, 4'b0000);
    step();
    chk("rst_holds_r1", out_a, 8'h00);
    rst_n = 1'b1;
    step();
    chk("post_rst_inc_r1", out_a, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
